// File: rtl/mc_seq_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, opcodes,
// select encodings, fault codes and the EXEC-stage ALU decode helpers.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_FETCH_TO = 2'd1,
    FLT_ILLEGAL  = 2'd2,
    FLT_DATA_TO  = 2'd3
  } fault_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;
  localparam logic [1:0] PC_JAL    = 2'd3;

  localparam logic [1:0] WB_IMM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_MDR = 2'd2;
  localparam logic [1:0] WB_PC4 = 2'd3;

  localparam logic RHS_B   = 1'b0;
  localparam logic RHS_IMM = 1'b1;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  // Opcodes that proceed from DECODE to EXEC (SYSTEM is handled separately).
  function automatic logic is_exec_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LUI);
  endfunction

  // ALU operation for EXEC; only shifts-right distinguish SRL/SRA on I-ALU.
  function automatic logic [3:0] exec_alu_op(input logic [6:0] op,
                                             input logic [2:0] f3,
                                             input logic       f7_5);
    logic [3:0] res;
    res = 4'b0000;
    case (op)
      OP_R:                      res = {f7_5, f3};
      OP_IALU:                   res = {(f3 == F3_SR) & f7_5, f3};
      OP_LOAD, OP_STORE, OP_JALR: res = ALU_ADD;
      OP_BRANCH:                 res = ALU_SUB;
      default:                   res = 4'b0000;
    endcase
    return res;
  endfunction

  // Immediate operand is used by I-ALU, address generation and JALR.
  function automatic logic exec_rhs_imm(input logic [6:0] op);
    return (op == OP_IALU) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Instruction/data memory handshake bundle between sequencer and memories.
// Handshake: a req, once raised, stays high and unchanged (including
// dm_write) until the cycle its ack is seen high; the transfer completes in
// that ack cycle (read data valid in the same cycle) and req may drop next.
interface mc_sequencer_if;
  logic im_req;
  logic im_ack;
  logic dm_req;
  logic dm_ack;
  logic dm_write;

  modport master (output im_req, output dm_req, output dm_write,
                  input im_ack, input dm_ack);
  modport slave  (input im_req, input dm_req, input dm_write,
                  output im_ack, output dm_ack);
endinterface

// File: rtl/mc_wait_timer.sv
// Wait-state timer: counts cycles an outstanding request goes unanswered and
// flags expiry once the count reaches TIMEOUT. TIMEOUT = 0 never expires.
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

  // Wait counter; parks at LIMIT so expiry is stable until cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (TIMEOUT != 0) && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack
// memories, bus timeout and illegal-instruction faults, halt on SYSTEM, and
// cycle / retired-instruction counters.
module mc_sequencer
  import mc_seq_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       inst_opcode,
  input  logic [2:0]       inst_func3,
  input  logic [6:0]       inst_func7,
  input  logic             alu_zero,
  mc_sequencer_if.master   mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_update_sel,
  output logic             regs_write,
  output logic [3:0]       alu_op,
  output logic             alu_rhs_sel,
  output logic [1:0]       reg_writeback_sel,
  output logic [2:0]       state,
  output logic             stat,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  state_t state_q, state_next;
  fault_t fault_q, fault_next;
  logic   im_req_c, dm_req_c, dm_write_c, retire;
  logic   timer_clear, timer_count, timer_expired;
  logic   br_taken;

  // Only func7[5] selects an ALU variant; the rest of func7 is immediate bits.
  logic unused_func7;
  assign unused_func7 = ^{inst_func7[6], inst_func7[4:0]};

  assign mem.im_req   = im_req_c;
  assign mem.dm_req   = dm_req_c;
  assign mem.dm_write = dm_write_c;

  assign state      = state_q;
  assign fault_code = fault_q;
  assign stat       = (state_q == ST_HALT) || (state_q == ST_FAULT);
  assign br_taken   = (inst_func3 == F3_BEQ) ? alu_zero : !alu_zero;

  assign timer_count = (im_req_c && !mem.im_ack) || (dm_req_c && !mem.dm_ack);
  assign timer_clear = !timer_count;

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .count   (timer_count),
    .expired (timer_expired)
  );

  // State and fault-code registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_next;
      fault_q <= fault_next;
    end
  end

  // Next-state and datapath strobes from state, IR fields and acks.
  always_comb begin
    state_next        = state_q;
    fault_next        = fault_q;
    retire            = 1'b0;
    im_req_c          = 1'b0;
    dm_req_c          = 1'b0;
    dm_write_c        = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_update_sel     = PC_PLUS4;
    regs_write        = 1'b0;
    alu_op            = 4'b0000;
    alu_rhs_sel       = RHS_B;
    reg_writeback_sel = WB_IMM;
    case (state_q)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        im_req_c = 1'b1;
        if (mem.im_ack) begin
          ir_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (timer_expired) begin
          state_next = ST_FAULT;
          fault_next = FLT_FETCH_TO;
        end
      end
      ST_DECODE: begin
        if (is_exec_op(inst_opcode)) begin
          state_next = ST_EXEC;
        end else if (inst_opcode == OP_SYSTEM) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_FAULT;
          fault_next = FLT_ILLEGAL;
        end
      end
      ST_EXEC: begin
        alu_op      = exec_alu_op(inst_opcode, inst_func3, inst_func7[5]);
        alu_rhs_sel = exec_rhs_imm(inst_opcode);
        if ((inst_opcode == OP_LOAD) || (inst_opcode == OP_STORE)) begin
          state_next = ST_MEM;
        end else if (inst_opcode == OP_BRANCH) begin
          if ((inst_func3 == F3_BEQ) || (inst_func3 == F3_BNE)) begin
            pc_write      = 1'b1;
            pc_update_sel = br_taken ? PC_BRANCH : PC_PLUS4;
            retire        = 1'b1;
            state_next    = ST_FETCH;
          end else begin
            state_next = ST_FAULT;
            fault_next = FLT_ILLEGAL;
          end
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        dm_req_c   = 1'b1;
        dm_write_c = (inst_opcode == OP_STORE);
        if (mem.dm_ack) begin
          if (inst_opcode == OP_STORE) begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timer_expired) begin
          state_next = ST_FAULT;
          fault_next = FLT_DATA_TO;
        end
      end
      ST_WB: begin
        regs_write = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
        case (inst_opcode)
          OP_R, OP_IALU:   reg_writeback_sel = WB_ALU;
          OP_LOAD:         reg_writeback_sel = WB_MDR;
          OP_JAL, OP_JALR: reg_writeback_sel = WB_PC4;
          default:         reg_writeback_sel = WB_IMM;
        endcase
        if (inst_opcode == OP_JAL) begin
          pc_update_sel = PC_JAL;
        end else if (inst_opcode == OP_JALR) begin
          pc_update_sel = PC_ALU;
        end
      end
      ST_HALT, ST_FAULT: state_next = state_q;
      default: state_next = ST_IDLE;
    endcase
  end

  // Active-cycle and retired-instruction counters (wrap naturally).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if ((state_q != ST_IDLE) && !stat) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (retire) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mc_sequencer.sv
// Directed testbench for mc_sequencer: a vector table of single instructions
// with zero-wait memories, then hand-written wait-state, timeout, fault,
// halt and mid-transaction reset sequences.
module tb_mc_sequencer;

  logic        clk;
  logic        rst;
  logic [6:0]  inst_opcode;
  logic [2:0]  inst_func3;
  logic [6:0]  inst_func7;
  logic        alu_zero;
  logic        ir_write, pc_write, regs_write, alu_rhs_sel, stat;
  logic [1:0]  pc_update_sel, reg_writeback_sel, fault_code;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  mc_sequencer_if mif ();

  mc_sequencer #(.TIMEOUT(15), .CNT_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .inst_opcode       (inst_opcode),
    .inst_func3        (inst_func3),
    .inst_func7        (inst_func7),
    .alu_zero          (alu_zero),
    .mem               (mif),
    .ir_write          (ir_write),
    .pc_write          (pc_write),
    .pc_update_sel     (pc_update_sel),
    .regs_write        (regs_write),
    .alu_op            (alu_op),
    .alu_rhs_sel       (alu_rhs_sel),
    .reg_writeback_sel (reg_writeback_sel),
    .state             (state),
    .stat              (stat),
    .fault_code        (fault_code),
    .cycle_cnt         (cycle_cnt),
    .instret_cnt       (instret_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- vector record ----------------
  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        zero;
    int          cyc;    // cycles from FETCH to next FETCH
    logic [23:0] trace;  // visited states, one octal digit per cycle
    logic        rw;
    logic [1:0]  wbs;
    logic        pw;
    logic [1:0]  pcs;
    logic [3:0]  aop;
    logic        rhs;
    logic        dmw;
  } vec_t;

  vec_t vecs[14];

  int total = 0;
  int bad   = 0;

  // Observations of the last run_instr call.
  int          obs_cyc, obs_fetch, obs_mem;
  logic [23:0] obs_trace;
  logic        obs_rw, obs_pw, obs_rhs, obs_dmw;
  logic [1:0]  obs_wbs, obs_pcs;
  logic [3:0]  obs_aop;
  logic [2:0]  obs_end;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    rst = 1'b0;
    mif.im_ack = 1'b0;
    mif.dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs one instruction, acking fetch after im_wait and data after dm_wait
  // unanswered cycles. Stops at the next FETCH, at HALT/FAULT, or after
  // 'limit' counted cycles (limit 0 = no limit). Entered and left at a
  // falling edge, with outputs of the stop cycle not yet influenced by acks.
  task automatic run_instr(input vec_t v, input int im_wait, input int dm_wait, input int limit);
    logic [2:0] st;
    bit first, left, done;
    int fetch_n, mem_n;
    inst_opcode = v.opc;
    inst_func3  = v.f3;
    inst_func7  = v.f7;
    alu_zero    = v.zero;
    obs_cyc = 0; obs_fetch = 0; obs_mem = 0; obs_trace = '0;
    obs_rw = 0; obs_pw = 0; obs_rhs = 0; obs_dmw = 0;
    obs_wbs = '0; obs_pcs = '0; obs_aop = '0; obs_end = '0;
    first = 1; left = 0; done = 0; fetch_n = 0; mem_n = 0;
    for (int k = 0; k < 200; k++) begin
      if (!first) @(negedge clk);
      first = 0;
      st = state;
      if (st == 3'd0) begin
        mif.im_ack = 1'b0;
        mif.dm_ack = 1'b0;
        continue;
      end
      if ((st == 3'd6) || (st == 3'd7) || (left && st == 3'd1) ||
          (limit != 0 && obs_cyc == limit)) begin
        obs_end = st;
        done = 1;
        break;
      end
      if (st != 3'd1) left = 1;
      mif.im_ack = (st == 3'd1) && (fetch_n == im_wait);
      mif.dm_ack = (st == 3'd4) && (mem_n == dm_wait);
      if (st == 3'd1) fetch_n++;
      if (st == 3'd4) mem_n++;
      #1;
      obs_trace = {obs_trace[20:0], state};
      obs_cyc++;
      if (mif.im_req) obs_fetch++;
      if (mif.dm_req) begin
        obs_mem++;
        obs_dmw = obs_dmw | mif.dm_write;
      end
      if (regs_write) begin
        obs_rw  = 1'b1;
        obs_wbs = reg_writeback_sel;
      end
      if (pc_write) begin
        obs_pw  = 1'b1;
        obs_pcs = pc_update_sel;
      end
      if (st == 3'd3) begin
        obs_aop = alu_op;
        obs_rhs = alu_rhs_sel;
      end
    end
    if (!done) chk("run_budget", 32'd0, 32'd1);
  endtask

  // ---------------- test ----------------
  int   exp_cyc;
  int   exp_ret;
  vec_t v;

  initial begin
    //             opc          f3      f7           z  cyc trace     rw wbs  pw pcs  aop      rhs  dmw
    vecs[0]  = '{7'b0110011, 3'b000, 7'b0000000, 0, 4, 24'o1235,  1, 2'd1, 1, 2'd0, 4'b0000, 0, 0}; // ADD
    vecs[1]  = '{7'b0110011, 3'b000, 7'b0100000, 0, 4, 24'o1235,  1, 2'd1, 1, 2'd0, 4'b1000, 0, 0}; // SUB
    vecs[2]  = '{7'b0110011, 3'b101, 7'b0100000, 0, 4, 24'o1235,  1, 2'd1, 1, 2'd0, 4'b1101, 0, 0}; // SRA
    vecs[3]  = '{7'b0010011, 3'b101, 7'b0100000, 0, 4, 24'o1235,  1, 2'd1, 1, 2'd0, 4'b1101, 1, 0}; // SRAI
    vecs[4]  = '{7'b0010011, 3'b000, 7'b0100000, 0, 4, 24'o1235,  1, 2'd1, 1, 2'd0, 4'b0000, 1, 0}; // ADDI neg imm
    vecs[5]  = '{7'b0100011, 3'b010, 7'b0000000, 0, 4, 24'o1234,  0, 2'd0, 1, 2'd0, 4'b0000, 1, 1}; // SW
    vecs[6]  = '{7'b0000011, 3'b010, 7'b0000000, 0, 5, 24'o12345, 1, 2'd2, 1, 2'd0, 4'b0000, 1, 0}; // LW
    vecs[7]  = '{7'b1100011, 3'b000, 7'b0000000, 1, 3, 24'o123,   0, 2'd0, 1, 2'd1, 4'b1000, 0, 0}; // BEQ taken
    vecs[8]  = '{7'b1100011, 3'b000, 7'b0000000, 0, 3, 24'o123,   0, 2'd0, 1, 2'd0, 4'b1000, 0, 0}; // BEQ not taken
    vecs[9]  = '{7'b1100011, 3'b001, 7'b0000000, 0, 3, 24'o123,   0, 2'd0, 1, 2'd1, 4'b1000, 0, 0}; // BNE taken
    vecs[10] = '{7'b1100011, 3'b001, 7'b0000000, 1, 3, 24'o123,   0, 2'd0, 1, 2'd0, 4'b1000, 0, 0}; // BNE not taken
    vecs[11] = '{7'b1101111, 3'b111, 7'b0100000, 0, 4, 24'o1235,  1, 2'd3, 1, 2'd3, 4'b0000, 0, 0}; // JAL
    vecs[12] = '{7'b1100111, 3'b000, 7'b0000000, 0, 4, 24'o1235,  1, 2'd3, 1, 2'd2, 4'b0000, 1, 0}; // JALR
    vecs[13] = '{7'b0110111, 3'b101, 7'b0100000, 0, 4, 24'o1235,  1, 2'd0, 1, 2'd0, 4'b0000, 0, 0}; // LUI

    rst = 1'b0;
    inst_opcode = '0; inst_func3 = '0; inst_func7 = '0; alu_zero = 1'b0;
    mif.im_ack = 1'b0;
    mif.dm_ack = 1'b0;

    // Reset values.
    @(negedge clk); #1;
    chk("rst_state", state, 3'd0);
    chk("rst_strobes", {mif.im_req, mif.dm_req, mif.dm_write, ir_write, pc_write, regs_write}, 6'd0);
    chk("rst_alu", {alu_op, alu_rhs_sel}, 5'd0);
    chk("rst_sels", {pc_update_sel, reg_writeback_sel}, 4'd0);
    chk("rst_stat", {stat, fault_code}, 3'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_instret", instret_cnt, 32'd0);

    // Reset release: one IDLE cycle precedes the first FETCH.
    do_reset();
    #1 chk("idle_after_release", state, 3'd0);

    // Vector table, back to back with zero-wait memories.
    exp_cyc = 0;
    exp_ret = 0;
    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i], 0, 0, 0);
      exp_cyc += vecs[i].cyc;
      exp_ret++;
      chk($sformatf("v%0d_cycles", i), obs_cyc, vecs[i].cyc);
      chk($sformatf("v%0d_trace", i), obs_trace, vecs[i].trace);
      chk($sformatf("v%0d_regs_write", i), obs_rw, vecs[i].rw);
      chk($sformatf("v%0d_wb_sel", i), obs_wbs, vecs[i].wbs);
      chk($sformatf("v%0d_pc_write", i), obs_pw, vecs[i].pw);
      chk($sformatf("v%0d_pc_sel", i), obs_pcs, vecs[i].pcs);
      chk($sformatf("v%0d_alu_op", i), obs_aop, vecs[i].aop);
      chk($sformatf("v%0d_rhs_sel", i), obs_rhs, vecs[i].rhs);
      chk($sformatf("v%0d_dm_write", i), obs_dmw, vecs[i].dmw);
      chk($sformatf("v%0d_end_state", i), obs_end, 3'd1);
      chk($sformatf("v%0d_cycle_cnt", i), cycle_cnt, exp_cyc);
      chk($sformatf("v%0d_instret", i), instret_cnt, exp_ret);
    end

    // LOAD with three data wait states.
    do_reset();
    run_instr(vecs[6], 0, 3, 0);
    chk("ldwait_dm_req_cycles", obs_mem, 4);
    chk("ldwait_dm_write", obs_dmw, 1'b0);
    chk("ldwait_wb_sel", obs_wbs, 2'd2);
    chk("ldwait_cycle_cnt", cycle_cnt, 32'd8);
    chk("ldwait_instret", instret_cnt, 32'd1);

    // Fetch ack in the very cycle the timer reaches TIMEOUT still wins.
    do_reset();
    run_instr(vecs[0], 15, 0, 0);
    chk("fetch_edge_end", obs_end, 3'd1);
    chk("fetch_edge_req_cycles", obs_fetch, 16);
    chk("fetch_edge_cycle_cnt", cycle_cnt, 32'd19);
    chk("fetch_edge_fault", fault_code, 2'd0);

    // Fetch timeout: no ack ever.
    do_reset();
    run_instr(vecs[0], 1000, 0, 0);
    chk("fetch_to_state", obs_end, 3'd7);
    chk("fetch_to_req_cycles", obs_fetch, 16);
    chk("fetch_to_code", fault_code, 2'd1);
    chk("fetch_to_stat", stat, 1'b1);
    chk("fetch_to_cycle_cnt", cycle_cnt, 32'd16);
    repeat (5) @(negedge clk);
    #1;
    chk("fetch_to_frozen_cycle", cycle_cnt, 32'd16);
    chk("fetch_to_frozen_instret", instret_cnt, 32'd0);
    chk("fetch_to_strobes", {mif.im_req, mif.dm_req, ir_write, pc_write, regs_write}, 5'd0);
    chk("fetch_to_absorb", state, 3'd7);

    // Data timeout on a LOAD.
    do_reset();
    run_instr(vecs[6], 0, 1000, 0);
    chk("data_to_state", obs_end, 3'd7);
    chk("data_to_req_cycles", obs_mem, 16);
    chk("data_to_code", fault_code, 2'd3);
    chk("data_to_cycle_cnt", cycle_cnt, 32'd19);

    // Illegal opcode 0x7F.
    do_reset();
    v = vecs[0];
    v.opc = 7'h7f;
    run_instr(v, 0, 0, 0);
    chk("illegal_state", obs_end, 3'd7);
    chk("illegal_trace", obs_trace, 24'o12);
    chk("illegal_code", fault_code, 2'd2);
    chk("illegal_stat", stat, 1'b1);
    chk("illegal_cycle_cnt", cycle_cnt, 32'd2);

    // Branch with unsupported func3 faults without touching the PC.
    do_reset();
    v = vecs[7];
    v.f3 = 3'b100;
    run_instr(v, 0, 0, 0);
    chk("badbr_state", obs_end, 3'd7);
    chk("badbr_code", fault_code, 2'd2);
    chk("badbr_pc_write", obs_pw, 1'b0);
    chk("badbr_instret", instret_cnt, 32'd0);

    // ECALL halts cleanly.
    do_reset();
    v = vecs[0];
    v.opc = 7'b1110011;
    run_instr(v, 0, 0, 0);
    #1;
    chk("ecall_state", state, 3'd6);
    chk("ecall_stat", stat, 1'b1);
    chk("ecall_code", fault_code, 2'd0);
    chk("ecall_strobes", {mif.im_req, mif.dm_req, ir_write, pc_write, regs_write}, 5'd0);

    // Reset asserted while a STORE waits in MEM.
    do_reset();
    run_instr(vecs[5], 0, 1000, 5);
    chk("midrst_pre_state", state, 3'd4);
    chk("midrst_pre_req", {mif.dm_req, mif.dm_write}, 2'b11);
    rst = 1'b0;
    #1;
    chk("midrst_req", {mif.dm_req, mif.dm_write}, 2'b00);
    chk("midrst_writes", {pc_write, regs_write}, 2'b00);
    chk("midrst_state", state, 3'd0);
    chk("midrst_cycle_cnt", cycle_cnt, 32'd0);
    chk("midrst_instret", instret_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
